sdram_responder: RTL

SDRAM_RESPONDER -- requirements
Module: sdram_responder

---
 rtl/sdram_responder.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device model: decodes controller commands, tracks per-bank row
// state, stores words in byte-lane block RAM and returns read data after CAS latency.
module sdram_responder #(
   parameter int ROW_AW = 4,
   parameter int TRCD   = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sd_cs,
   input  logic        sd_ras,
   input  logic        sd_cas,
   input  logic        sd_we,
   input  logic [1:0]  sd_ba,
   input  logic [12:0] sd_addr,
   input  logic [1:0]  sd_dqm,
   input  logic [15:0] dq_i,
   output logic [15:0] dq_o,
   output logic [1:0]  dq_oe,
   output logic        mode_valid,
   output logic [1:0]  cas_lat,
   output logic [15:0] refresh_cnt,
   output logic        err,
   output logic [2:0]  err_code
);
   localparam int AW    = 2 + ROW_AW + 9;
   localparam int DEPTH = 1 << AW;
   localparam int CW    = $clog2(TRCD + 2);
   localparam logic [CW-1:0] TRCD_C = CW'(TRCD);

   typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_t;
   typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS} cmd_t;

   cmd_t              cmd;
   bank_t             bank_q [4];
   bank_t             bank_d [4];
   logic [ROW_AW-1:0] row_q  [4];
   logic [ROW_AW-1:0] row_d  [4];
   logic [CW-1:0]     cnt_q  [4];
   logic [CW-1:0]     cnt_d  [4];
   logic              mode_valid_q, mode_valid_d;
   logic [1:0]        cas_lat_q, cas_lat_d;
   logic [15:0]       refresh_q, refresh_d;
   logic              err_q, err_d;
   logic [2:0]        err_code_q, err_code_d;
   logic [2:0]        code;
   logic              wr_en, rd_en, any_active, ba_active, mode_legal;

   // Read pipeline: stage 0 holds the command, the RAM output joins at stage 1
   logic [2:0]        p_vld_q;
   logic [1:0]        p_oe_q [3];
   logic [15:0]       p_dat1_q, p_dat2_q;
   logic [15:0]       dq_o_q;
   logic [1:0]        dq_oe_q;
   logic              sel_vld;
   logic [1:0]        sel_oe;
   logic [15:0]       sel_dat;

   logic [AW-1:0]     mem_addr;
   logic [15:0]       rd_data;
   logic              unused_addr;

   assign unused_addr = ^sd_addr;

   always_comb begin
      cmd = CMD_NOP;
      if (!sd_cs) begin
         case ({sd_ras, sd_cas, sd_we})
            3'b011:  cmd = CMD_ACT;
            3'b101:  cmd = CMD_RD;
            3'b100:  cmd = CMD_WR;
            3'b010:  cmd = CMD_PRE;
            3'b001:  cmd = CMD_REF;
            3'b000:  cmd = CMD_MRS;
            default: cmd = CMD_NOP;
         endcase
      end
   end

   always_comb begin
      bank_d       = bank_q;
      row_d        = row_q;
      cnt_d        = cnt_q;
      mode_valid_d = mode_valid_q;
      cas_lat_d    = cas_lat_q;
      refresh_d    = refresh_q;
      err_d        = err_q;
      err_code_d   = err_code_q;
      code         = 3'd0;
      wr_en        = 1'b0;
      rd_en        = 1'b0;
      any_active   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bank_q[i] == BANK_ACTIVE) begin
            any_active = 1'b1;
            if (cnt_q[i] < TRCD_C) cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
      ba_active  = (bank_q[sd_ba] == BANK_ACTIVE);
      mode_legal = ((sd_addr[6:4] == 3'd2) || (sd_addr[6:4] == 3'd3)) && (sd_addr[2:0] == 3'd0);

      case (cmd)
         CMD_ACT: begin
            if (!mode_valid_q)  code = 3'd5;
            else if (ba_active) code = 3'd2;
            else begin
               bank_d[sd_ba] = BANK_ACTIVE;
               row_d[sd_ba]  = sd_addr[ROW_AW-1:0];
               cnt_d[sd_ba]  = CW'(1);
            end
         end
         CMD_RD, CMD_WR: begin
            if (!mode_valid_q)                            code = 3'd5;
            else if (!ba_active)                          code = 3'd1;
            else if (cnt_q[sd_ba] < TRCD_C)               code = 3'd3;
            else if (cmd == CMD_WR && dq_oe_q != 2'b00)   code = 3'd7;
            else begin
               rd_en = (cmd == CMD_RD);
               wr_en = (cmd == CMD_WR);
               if (sd_addr[10]) bank_d[sd_ba] = BANK_IDLE;
            end
         end
         CMD_PRE: begin
            if (sd_addr[10]) begin
               for (int i = 0; i < 4; i++) bank_d[i] = BANK_IDLE;
            end else begin
               bank_d[sd_ba] = BANK_IDLE;
            end
         end
         CMD_REF: begin
            if (any_active) code = 3'd4;
            else            refresh_d = refresh_q + 16'd1;
         end
         CMD_MRS: begin
            if (any_active) code = 3'd4;
            else if (!mode_legal) begin
               code         = 3'd6;
               mode_valid_d = 1'b0;
            end else begin
               mode_valid_d = 1'b1;
               cas_lat_d    = sd_addr[5:4];
            end
         end
         default: ;
      endcase

      if (code != 3'd0) begin
         err_d = 1'b1;
         if (!err_q) err_code_d = code;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            bank_q[i] <= BANK_IDLE;
            row_q[i]  <= '0;
            cnt_q[i]  <= '0;
         end
         mode_valid_q <= 1'b0;
         cas_lat_q    <= 2'd3;
         refresh_q    <= 16'd0;
         err_q        <= 1'b0;
         err_code_q   <= 3'd0;
      end else begin
         bank_q       <= bank_d;
         row_q        <= row_d;
         cnt_q        <= cnt_d;
         mode_valid_q <= mode_valid_d;
         cas_lat_q    <= cas_lat_d;
         refresh_q    <= refresh_d;
         err_q        <= err_d;
         err_code_q   <= err_code_d;
      end
   end

   assign mem_addr = {sd_ba, row_q[sd_ba], sd_addr[8:0]};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_q;
         always_ff @(posedge clk) begin
            if (wr_en && !sd_dqm[gi]) mem[mem_addr] <= dq_i[8*gi +: 8];
            rd_q <= mem[mem_addr];
         end
         assign rd_data[8*gi +: 8] = rd_q;
      end
   endgenerate

   always_comb begin
      sel_vld = p_vld_q[2];
      sel_oe  = p_oe_q[2];
      sel_dat = p_dat2_q;
      if (cas_lat_q == 2'd2) begin
         sel_vld = p_vld_q[1];
         sel_oe  = p_oe_q[1];
         sel_dat = p_dat1_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p_vld_q  <= 3'b000;
         for (int i = 0; i < 3; i++) p_oe_q[i] <= 2'b00;
         p_dat1_q <= 16'd0;
         p_dat2_q <= 16'd0;
         dq_o_q   <= 16'd0;
         dq_oe_q  <= 2'b00;
      end else begin
         p_vld_q  <= {p_vld_q[1:0], rd_en};
         p_oe_q[0] <= ~sd_dqm;
         p_oe_q[1] <= p_oe_q[0];
         p_oe_q[2] <= p_oe_q[1];
         p_dat1_q <= rd_data;
         p_dat2_q <= p_dat1_q;
         dq_o_q   <= sel_vld ? sel_dat : 16'd0;
         dq_oe_q  <= sel_vld ? sel_oe : 2'b00;
      end
   end

   assign dq_o        = dq_o_q;
   assign dq_oe       = dq_oe_q;
   assign mode_valid  = mode_valid_q;
   assign cas_lat     = cas_lat_q;
   assign refresh_cnt = refresh_q;
   assign err         = err_q;
   assign err_code    = err_code_q;
endmodule
